// File: rtl/eth_tc_csr_pkg.sv
// Shared types and constants for the traffic-controller CSR router.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_tc_csr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Local offsets served by the router itself, never forwarded to a channel
  localparam logic [11:0] OFF_PAUSE  = 12'h80E;
  localparam logic [11:0] OFF_PFC    = 12'h80F;
  localparam logic [11:0] OFF_HOLD   = 12'h810;
  localparam logic [11:0] OFF_STATUS = 12'h811;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // STATUS bit positions (sticky, write-1-to-clear)
  localparam int STS_TIMEOUT = 0;
  localparam int STS_DECERR  = 1;

  function automatic logic is_local_off(input logic [11:0] off);
    return (off == OFF_PAUSE) || (off == OFF_PFC) ||
           (off == OFF_HOLD)  || (off == OFF_STATUS);
  endfunction

endpackage

// File: rtl/eth_tc_pause_ch.sv
// Per-channel PAUSE/PFC/HOLD/STATUS registers with pause auto-clear hold counter.
// Latency: register outputs update on the write edge; auto-clear HOLD cycles after the last PAUSE/PFC write.
// Backpressure: none, every strobe is accepted in the cycle it is presented.
module eth_tc_pause_ch
  import eth_tc_csr_pkg::*;
#(
  parameter int PFC_W  = 8,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_pause,
  input  logic              wr_pfc,
  input  logic              wr_hold,
  input  logic [1:0]        pause_wdat,
  input  logic [PFC_W-1:0]  pfc_wdat,
  input  logic [HOLD_W-1:0] hold_wdat,
  input  logic [1:0]        sts_clr,
  input  logic [1:0]        sts_set,
  output logic [1:0]        pause,
  output logic [PFC_W-1:0]  pfc,
  output logic [HOLD_W-1:0] hold,
  output logic [1:0]        status
);

  logic [1:0]        pause_q, pause_d;
  logic [PFC_W-1:0]  pfc_q, pfc_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [1:0]        status_q, status_d;

  // Next-state: countdown/expiry first so a same-cycle write overrides the clear
  always_comb begin
    pause_d  = pause_q;
    pfc_d    = pfc_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - HOLD_W'(1);
      if (cnt_q == HOLD_W'(1)) begin
        pause_d = '0;
        pfc_d   = '0;
      end
    end
    if (wr_pause) pause_d = pause_wdat;
    if (wr_pfc)   pfc_d   = pfc_wdat;
    // HOLD=0 loads 0, which leaves the counter idle (no auto-clear)
    if (wr_pause || wr_pfc) cnt_d = hold_q;
    if (wr_hold) hold_d = hold_wdat;
    // A new error event is never lost to a concurrent clear
    status_d = (status_q & ~sts_clr) | sts_set;
  end

  // Register update with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pause_q  <= '0;
      pfc_q    <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
      status_q <= '0;
    end else begin
      pause_q  <= pause_d;
      pfc_q    <= pfc_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  assign pause  = pause_q;
  assign pfc    = pfc_q;
  assign hold   = hold_q;
  assign status = status_q;

endmodule

// File: rtl/eth_tc_csr_router.sv
// Avalon-MM CSR fan-out to NUM_CH traffic-controller ports plus local pause/PFC sideband registers.
// Latency: local/decode-error access 1 wait cycle; forwarded access 1 + FWD cycles, bounded by TIMEOUT_CYCLES.
// Backpressure: csr_waitrequest held until RESP; a channel stalling past the timeout is answered with ERR_DATA.
module eth_tc_csr_router
  import eth_tc_csr_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int PFC_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HOLD_W         = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    csr_read,
  input  logic                    csr_write,
  input  logic [15:0]             csr_address,
  input  logic [31:0]             csr_writedata,
  output logic [31:0]             csr_readdata,
  output logic                    csr_waitrequest,
  output logic [NUM_CH-1:0]       ch_read,
  output logic [NUM_CH-1:0]       ch_write,
  output logic [11:0]             ch_address,
  output logic [31:0]             ch_writedata,
  input  logic [NUM_CH*32-1:0]    ch_readdata,
  input  logic [NUM_CH-1:0]       ch_waitrequest,
  output logic [NUM_CH*2-1:0]     pause_data,
  output logic [NUM_CH*PFC_W-1:0] pfc_pause_data
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   rd_q, rd_d, wr_q, wr_d, sel_q, sel_d;
  logic [11:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic                cmd, is_wr, dec_err, is_local, sel_wait;
  logic [3:0]          csr_ch;
  logic [11:0]         csr_off;
  logic [NUM_CH-1:0]   ch_dec, wr_pause, wr_pfc, wr_hold;
  logic [31:0]         loc_rdata, sel_rdata;
  logic [NUM_CH-1:0][1:0]        sts_clr, sts_set, pause_r, status_r;
  logic [NUM_CH-1:0][PFC_W-1:0]  pfc_r;
  logic [NUM_CH-1:0][HOLD_W-1:0] hold_r;

  // Address decode, local register read mux and selected-channel response mux
  always_comb begin
    cmd       = csr_read | csr_write;
    is_wr     = csr_write & ~csr_read;  // read+write together behaves as a read
    csr_ch    = csr_address[15:12];
    csr_off   = csr_address[11:0];
    dec_err   = 32'(csr_ch) >= 32'(NUM_CH);
    is_local  = is_local_off(csr_off);
    ch_dec    = '0;
    loc_rdata = '0;
    sel_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_dec[c] = (csr_ch == 4'(c));
      if (ch_dec[c]) begin
        case (csr_off)
          OFF_PAUSE:  loc_rdata = 32'(pause_r[c]);
          OFF_PFC:    loc_rdata = 32'(pfc_r[c]);
          OFF_HOLD:   loc_rdata = 32'(hold_r[c]);
          OFF_STATUS: loc_rdata = 32'(status_r[c]);
          default:    loc_rdata = '0;
        endcase
      end
      if (sel_q[c]) sel_rdata = ch_readdata[c*32 +: 32];
    end
    sel_wait = |(sel_q & ch_waitrequest);
  end

  // Access FSM: next state, forwarded strobes, timer, response data and local register strobes
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    timer_d  = timer_q;
    rdata_d  = rdata_q;
    wr_pause = '0;
    wr_pfc   = '0;
    wr_hold  = '0;
    sts_clr  = '0;
    sts_set  = '0;
    case (state_q)
      IDLE: begin
        if (cmd) begin
          if (dec_err) begin
            state_d = RESP;
            rdata_d = ERR_DATA;
            sts_set[0][STS_DECERR] = 1'b1;
          end else if (is_local) begin
            state_d = RESP;
            rdata_d = loc_rdata;
            if (is_wr) begin
              for (int c = 0; c < NUM_CH; c++) begin
                wr_pause[c] = ch_dec[c] && (csr_off == OFF_PAUSE);
                wr_pfc[c]   = ch_dec[c] && (csr_off == OFF_PFC);
                wr_hold[c]  = ch_dec[c] && (csr_off == OFF_HOLD);
                if (ch_dec[c] && (csr_off == OFF_STATUS)) sts_clr[c] = csr_writedata[1:0];
              end
            end
          end else begin
            state_d = FWD;
            addr_d  = csr_off;
            wdata_d = csr_writedata;
            sel_d   = ch_dec;
            rd_d    = is_wr ? '0 : ch_dec;
            wr_d    = is_wr ? ch_dec : '0;
            timer_d = '0;
          end
        end
      end
      FWD: begin
        if (!sel_wait) begin
          state_d = RESP;
          rd_d    = '0;
          wr_d    = '0;
          rdata_d = sel_rdata;
        end else if (timer_q == TMR_LAST) begin
          state_d = RESP;
          rd_d    = '0;
          wr_d    = '0;
          rdata_d = ERR_DATA;
          for (int c = 0; c < NUM_CH; c++) sts_set[c][STS_TIMEOUT] = sel_q[c];
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;  // RESP lasts exactly one cycle
    endcase
  end

  // FSM and forwarding registers; reset drops strobes with no response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      timer_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    eth_tc_pause_ch #(
      .PFC_W  (PFC_W),
      .HOLD_W (HOLD_W)
    ) u_pause_ch (
      .clk        (clk),
      .reset      (reset),
      .wr_pause   (wr_pause[g]),
      .wr_pfc     (wr_pfc[g]),
      .wr_hold    (wr_hold[g]),
      .pause_wdat (csr_writedata[1:0]),
      .pfc_wdat   (csr_writedata[PFC_W-1:0]),
      .hold_wdat  (csr_writedata[HOLD_W-1:0]),
      .sts_clr    (sts_clr[g]),
      .sts_set    (sts_set[g]),
      .pause      (pause_r[g]),
      .pfc        (pfc_r[g]),
      .hold       (hold_r[g]),
      .status     (status_r[g])
    );
  end

  assign csr_waitrequest = ~reset & cmd & (state_q != RESP);
  assign csr_readdata    = rdata_q;
  assign ch_read         = rd_q;
  assign ch_write        = wr_q;
  assign ch_address      = addr_q;
  assign ch_writedata    = wdata_q;
  assign pause_data      = pause_r;
  assign pfc_pause_data  = pfc_r;

endmodule

// File: tb/tb_eth_tc_csr_router.sv
// Directed table-driven bench for eth_tc_csr_router with a per-channel stall model.
// Latency: n/a.
// Backpressure: channel model holds ch_waitrequest high for a programmable number of strobe cycles.
module tb_eth_tc_csr_router;

  logic         clk;
  logic         reset;
  logic         csr_read, csr_write;
  logic [15:0]  csr_address;
  logic [31:0]  csr_writedata, csr_readdata;
  logic         csr_waitrequest;
  logic [3:0]   ch_read, ch_write, ch_waitrequest;
  logic [11:0]  ch_address;
  logic [31:0]  ch_writedata;
  logic [127:0] ch_readdata;
  logic [7:0]   pause_data;
  logic [31:0]  pfc_pause_data;

  int checks = 0;
  int errors = 0;
  int stall  = 0;
  int cnt [4];

  eth_tc_csr_router #(
    .NUM_CH(4), .PFC_W(8), .TIMEOUT_CYCLES(16), .HOLD_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .csr_read(csr_read), .csr_write(csr_write), .csr_address(csr_address),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .csr_waitrequest(csr_waitrequest),
    .ch_read(ch_read), .ch_write(ch_write), .ch_address(ch_address),
    .ch_writedata(ch_writedata), .ch_readdata(ch_readdata),
    .ch_waitrequest(ch_waitrequest),
    .pause_data(pause_data), .pfc_pause_data(pfc_pause_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Channel model: stall for 'stall' strobe cycles, then accept (stall>=255 means stuck)
  initial begin
    ch_waitrequest = '1;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (ch_read[c] | ch_write[c]) cnt[c] = cnt[c] + 1;
        else cnt[c] = 0;
        ch_waitrequest[c] = !((ch_read[c] | ch_write[c]) && (cnt[c] > stall));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic csr_access(input string name, input logic rd, input logic wr,
                            input logic [15:0] addr, input logic [31:0] wd,
                            output logic [31:0] rdata, output int waits,
                            output logic [3:0] seen_rd, output logic [3:0] seen_wr,
                            output int strb_cyc);
    bit done;
    done = 0; waits = 0; seen_rd = '0; seen_wr = '0; strb_cyc = 0; rdata = '0;
    @(posedge clk);
    #1;
    csr_read = rd; csr_write = wr; csr_address = addr; csr_writedata = wd;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      seen_rd |= ch_read;
      seen_wr |= ch_write;
      if ((ch_read | ch_write) != 4'b0) strb_cyc++;
      if (csr_waitrequest) waits++;
      else begin
        rdata = csr_readdata;
        done  = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: no response within 100 cycles", name);
    end
    @(posedge clk);
    #1;
    csr_read = 1'b0; csr_write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
    int          stall;
    logic [31:0] exp_rdata;
    int          exp_waits;
    logic [3:0]  exp_strb;
    int          exp_cyc;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t vecs [21];

  initial begin
    logic [31:0] rdata;
    int          waits, cyc, n;
    logic [3:0]  srd, swr;
    string       nm;

    //               rd    wr    addr      wdata         stall rdata         waits strb     cyc addr
    vecs[0]  = '{1'b1, 1'b1, 16'h080E, 32'h3,        0,  32'h0,        1, 4'b0000, 0,  12'h000};
    vecs[1]  = '{1'b1, 1'b0, 16'h080E, 32'h0,        0,  32'h0,        1, 4'b0000, 0,  12'h000};
    vecs[2]  = '{1'b0, 1'b1, 16'h280E, 32'h3,        0,  32'h0,        1, 4'b0000, 0,  12'h000};
    vecs[3]  = '{1'b1, 1'b0, 16'h280E, 32'h0,        0,  32'h3,        1, 4'b0000, 0,  12'h000};
    vecs[4]  = '{1'b1, 1'b0, 16'h2810, 32'h0,        0,  32'h0,        1, 4'b0000, 0,  12'h000};
    vecs[5]  = '{1'b1, 1'b0, 16'h3004, 32'h0,        5,  32'h12345678, 7, 4'b1000, 6,  12'h004};
    vecs[6]  = '{1'b0, 1'b1, 16'h1020, 32'hABCD,     2,  32'h0,        4, 4'b0010, 3,  12'h020};
    vecs[7]  = '{1'b1, 1'b0, 16'h0100, 32'h0,        0,  32'hC0DE0000, 2, 4'b0001, 1,  12'h100};
    vecs[8]  = '{1'b1, 1'b0, 16'h27FF, 32'h0,        1,  32'hC0DE0002, 3, 4'b0100, 2,  12'h7FF};
    vecs[9]  = '{1'b1, 1'b0, 16'h5000, 32'h0,        0,  32'hDEADBEEF, 1, 4'b0000, 0,  12'h000};
    vecs[10] = '{1'b0, 1'b1, 16'h580E, 32'h3,        0,  32'h0,        1, 4'b0000, 0,  12'h000};
    vecs[11] = '{1'b1, 1'b0, 16'h0811, 32'h0,        0,  32'h2,        1, 4'b0000, 0,  12'h000};
    vecs[12] = '{1'b0, 1'b1, 16'h0811, 32'h2,        0,  32'h0,        1, 4'b0000, 0,  12'h000};
    vecs[13] = '{1'b1, 1'b0, 16'h0811, 32'h0,        0,  32'h0,        1, 4'b0000, 0,  12'h000};
    vecs[14] = '{1'b1, 1'b0, 16'h1040, 32'h0,        255, 32'hDEADBEEF, 17, 4'b0010, 16, 12'h040};
    vecs[15] = '{1'b1, 1'b0, 16'h1811, 32'h0,        0,  32'h1,        1, 4'b0000, 0,  12'h000};
    vecs[16] = '{1'b0, 1'b1, 16'h1811, 32'h1,        255, 32'h0,       1, 4'b0000, 0,  12'h000};
    vecs[17] = '{1'b1, 1'b0, 16'h1811, 32'h0,        0,  32'h0,        1, 4'b0000, 0,  12'h000};
    vecs[18] = '{1'b0, 1'b1, 16'h3080, 32'h55,       255, 32'h0,       17, 4'b1000, 16, 12'h080};
    vecs[19] = '{1'b1, 1'b0, 16'h3811, 32'h0,        0,  32'h1,        1, 4'b0000, 0,  12'h000};
    vecs[20] = '{1'b1, 1'b0, 16'h0811, 32'h0,        0,  32'h0,        1, 4'b0000, 0,  12'h000};

    ch_readdata = {32'h12345678, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    csr_write = 1'b0; csr_address = 16'h2004; csr_writedata = '0;
    csr_read  = 1'b1;  // command present during reset: waitrequest must still be 0
    reset = 1'b1;
    #23;
    chk("reset waitrequest", 32'(csr_waitrequest), 32'h0);
    chk("reset readdata", csr_readdata, 32'h0);
    chk("reset ch_read", 32'(ch_read), 32'h0);
    chk("reset ch_write", 32'(ch_write), 32'h0);
    chk("reset ch_address", 32'(ch_address), 32'h0);
    chk("reset ch_writedata", ch_writedata, 32'h0);
    chk("reset pause_data", 32'(pause_data), 32'h0);
    chk("reset pfc_pause_data", pfc_pause_data, 32'h0);
    csr_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 21; i++) begin
      stall = vecs[i].stall;
      nm = $sformatf("v%0d", i);
      csr_access(nm, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, rdata, waits, srd, swr, cyc);
      if (vecs[i].rd) chk({nm, " rdata"}, rdata, vecs[i].exp_rdata);
      chk({nm, " waits"}, 32'(waits), 32'(vecs[i].exp_waits));
      chk({nm, " ch_read seen"}, 32'(srd), vecs[i].rd ? 32'(vecs[i].exp_strb) : 32'h0);
      chk({nm, " ch_write seen"}, 32'(swr), vecs[i].rd ? 32'h0 : 32'(vecs[i].exp_strb));
      chk({nm, " strobe cycles"}, 32'(cyc), 32'(vecs[i].exp_cyc));
      if (vecs[i].exp_strb != 4'b0) begin
        chk({nm, " ch_address"}, 32'(ch_address), 32'(vecs[i].exp_addr));
        if (!vecs[i].rd) chk({nm, " ch_writedata"}, ch_writedata, vecs[i].wd);
      end
    end
    chk("pause after table", 32'(pause_data), 32'h30);
    chk("pfc after table", pfc_pause_data, 32'h0);

    // Hold auto-clear on ch1: HOLD=10, value visible for exactly 10 cycles
    stall = 0;
    csr_access("hold wr", 1'b0, 1'b1, 16'h1810, 32'd10, rdata, waits, srd, swr, cyc);
    csr_access("hold rd", 1'b1, 1'b0, 16'h1810, 32'h0, rdata, waits, srd, swr, cyc);
    chk("hold readback", rdata, 32'd10);
    csr_access("pfc wr", 1'b0, 1'b1, 16'h180F, 32'hA5, rdata, waits, srd, swr, cyc);
    chk("pfc set", pfc_pause_data, 32'h0000A500);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pfc_pause_data[15:8] == 8'hA5) n++;
      else break;
    end
    // The RESP cycle inside the access already showed the value once
    chk("pfc hold cycles", 32'(n + 1), 32'd10);
    chk("pfc cleared", pfc_pause_data, 32'h0);
    chk("pause ch2 kept (HOLD=0)", 32'(pause_data), 32'h30);

    // Rewrite landing exactly on the expiry edge keeps the new value and reloads
    csr_access("pfc wr2", 1'b0, 1'b1, 16'h180F, 32'hA5, rdata, waits, srd, swr, cyc);
    repeat (7) @(posedge clk);
    csr_access("pfc rewrite", 1'b0, 1'b1, 16'h180F, 32'h5A, rdata, waits, srd, swr, cyc);
    chk("pfc rewrite kept", pfc_pause_data, 32'h00005A00);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pfc_pause_data[15:8] == 8'h5A) n++;
      else break;
    end
    chk("pfc reload cycles", 32'(n + 1), 32'd10);
    chk("pfc cleared 2", pfc_pause_data, 32'h0);

    // Reset in the middle of a forwarded read
    stall = 255;
    @(posedge clk);
    #1;
    csr_read = 1'b1; csr_address = 16'h2000;
    repeat (3) @(negedge clk);
    chk("pre-reset ch_read", 32'(ch_read), 32'h4);
    reset = 1'b1;
    #1;
    chk("mid-reset ch_read", 32'(ch_read), 32'h0);
    chk("mid-reset pause", 32'(pause_data), 32'h0);
    chk("mid-reset waitrequest", 32'(csr_waitrequest), 32'h0);
    repeat (2) @(negedge clk);
    csr_read = 1'b0;
    reset = 1'b0;
    stall = 0;
    csr_access("post-reset local", 1'b1, 1'b0, 16'h280E, 32'h0, rdata, waits, srd, swr, cyc);
    chk("post-reset pause reg", rdata, 32'h0);
    csr_access("post-reset fwd", 1'b1, 1'b0, 16'h2000, 32'h0, rdata, waits, srd, swr, cyc);
    chk("post-reset fwd rdata", rdata, 32'hC0DE0002);
    chk("post-reset fwd waits", 32'(waits), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
